// File: rtl/data_ram_if.sv
// Request/response bundle between the CPU data-memory port and the data RAM responder.
interface data_ram_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        err_o;

    modport master (
        output ce_i, we_i, addr_i, sel_i, data_i,
        input  data_o, ack_o, err_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, sel_i, data_i,
        output data_o, ack_o, err_o
    );
endinterface

// File: rtl/data_ram_slave.sv
// Data-memory responder: one captured request per ce_i, served after WAIT_CYCLES wait states.
// Optional bus-error reporting for out-of-range addresses is enabled by DATA_RAM_BUSERR_EN.
module data_ram_slave #(
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    data_ram_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic            capture, enter_resp, addr_bad;

    logic            we_q, err_q;
    logic [AW-1:0]   idx_q;
    logic [3:0]      sel_q;
    logic [31:0]     wdata_q;

    logic            acc_we, acc_err;
    logic [AW-1:0]   acc_idx;
    logic [3:0]      acc_sel;
    logic [31:0]     acc_wdata;

    logic [31:0]     mem [2**AW];

`ifdef DATA_RAM_BUSERR_EN
    logic unused_addr;
    assign addr_bad    = |bus.addr_i[31:AW+2];
    assign unused_addr = ^bus.addr_i[1:0];
`else
    logic unused_addr;
    assign addr_bad    = 1'b0;
    assign unused_addr = ^{bus.addr_i[31:AW+2], bus.addr_i[1:0]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ce_i) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states the access is served on the capture edge itself,
    // so the live request inputs stand in for the not-yet-latched copy.
    always_comb begin
        acc_we    = we_q;
        acc_err   = err_q;
        acc_idx   = idx_q;
        acc_sel   = sel_q;
        acc_wdata = wdata_q;
        if (state == IDLE) begin
            acc_we    = bus.we_i;
            acc_err   = addr_bad;
            acc_idx   = bus.addr_i[AW+1:2];
            acc_sel   = bus.sel_i;
            acc_wdata = bus.data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= 4'd0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            bus.data_o <= 32'd0;
        end else begin
            if (capture) begin
                we_q    <= bus.we_i;
                err_q   <= addr_bad;
                idx_q   <= bus.addr_i[AW+1:2];
                sel_q   <= bus.sel_i;
                wdata_q <= bus.data_i;
                cnt     <= CNT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (enter_resp) begin
                if (acc_we && !acc_err) begin
                    for (int b = 0; b < 4; b++) begin
                        if (acc_sel[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                    end
                end
                bus.data_o <= (!acc_we && !acc_err) ? mem[acc_idx] : 32'd0;
            end else if (state == RESP) begin
                bus.data_o <= 32'd0;
            end
        end
    end

    assign bus.ack_o = (state == RESP) && !err_q;
    assign bus.err_o = (state == RESP) &&  err_q;

endmodule

// File: tb/tb_data_ram_slave.sv
// Bench for data_ram_slave: word-array/queue model for the WAIT_CYCLES=2 instance,
// plus directed literal checks on WAIT_CYCLES=0 and WAIT_CYCLES=3 instances.
module tb_data_ram_slave;
    localparam int WC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_ram_if bm ();
    data_ram_if i0 ();
    data_ram_if i3 ();

    data_ram_slave #(.AW(10), .WAIT_CYCLES(WC)) dut  (.clk(clk), .rst(rst), .bus(bm));
    data_ram_slave #(.AW(10), .WAIT_CYCLES(0))  dut0 (.clk(clk), .rst(rst), .bus(i0));
    data_ram_slave #(.AW(10), .WAIT_CYCLES(3))  dut3 (.clk(clk), .rst(rst), .bus(i3));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Model: a plain word array plus a queue of expected responses keyed by cycle.
    typedef struct {
        int          t;
        bit          err;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    logic [31:0] model_mem [1024];
    exp_t        q [$];

    function automatic void model_access(bit we, logic [31:0] addr, logic [3:0] sel,
                                         logic [31:0] data, int t);
        exp_t e;
        bit   bad;
        int   w;
        bad = 1'b0;
`ifdef DATA_RAM_BUSERR_EN
        bad = (addr[31:12] != 20'd0);
`endif
        w      = int'(addr[11:2]);
        e.t    = t;
        e.err  = bad;
        e.rd   = !we;
        e.data = (we || bad) ? 32'd0 : model_mem[w];
        if (we && !bad) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) model_mem[w][8*b +: 8] = data[8*b +: 8];
        end
        q.push_back(e);
    endfunction

    int          last_ack_cyc = -100;
    int          prev_ack_cyc = -100;
    int          last_err_cyc = -100;
    logic [31:0] last_ack_data = 32'd0;

    // Every cycle: ack/err exactly when the model says, data_o valid on reads, else 0.
    always @(negedge clk) begin
        bit          ea, ee, drd;
        logic [31:0] ed;
        if (!rst) q.delete();
        ea = 1'b0; ee = 1'b0; ed = 32'd0; drd = 1'b1;
        if (q.size() > 0 && q[0].t == cyc) begin
            ee  = q[0].err;
            ea  = !q[0].err;
            ed  = q[0].data;
            drd = q[0].rd || q[0].err;
            void'(q.pop_front());
        end
        chk("ack_o", {31'd0, bm.ack_o}, {31'd0, ea});
        chk("err_o", {31'd0, bm.err_o}, {31'd0, ee});
        if (drd) chk("data_o", bm.data_o, ed);
        if (bm.ack_o) begin
            prev_ack_cyc  = last_ack_cyc;
            last_ack_cyc  = cyc;
            last_ack_data = bm.data_o;
        end
        if (bm.err_o) last_err_cyc = cyc;
    end

    task automatic access(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] data, input bit hold, output int ncap);
        @(negedge clk);
        bm.ce_i = 1'b1; bm.we_i = we; bm.addr_i = addr; bm.sel_i = sel; bm.data_i = data;
        ncap = cyc + 1;
        model_access(we, addr, sel, data, ncap + WC);
        @(negedge clk);
        if (hold) begin
            repeat (WC + 1) @(negedge clk);
            model_access(we, addr, sel, data, ncap + WC + 2 + WC);
            @(negedge clk);
        end
        bm.ce_i = 1'b0; bm.we_i = ~we; bm.addr_i = $urandom; bm.data_i = $urandom;
        bm.sel_i = ~sel;
        repeat (WC + 1) @(negedge clk);
    endtask

    task automatic d3_access(input bit we, input logic [31:0] addr, input logic [31:0] data,
                             output logic [31:0] rd);
        int n;
        rd = 32'hxxxxxxxx;
        @(negedge clk);
        i3.ce_i = 1'b1; i3.we_i = we; i3.addr_i = addr; i3.sel_i = 4'hF; i3.data_i = data;
        n = cyc + 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin i3.ce_i = 1'b0; i3.addr_i = 32'h0; i3.data_i = 32'h0; end
            chk("d3_ack_timing", {31'd0, i3.ack_o}, {31'd0, (cyc == n + 3)});
            if (i3.ack_o) rd = i3.data_o;
        end
    endtask

    initial begin
        int          n;
        logic [31:0] rd;

        bm.ce_i = 1'b1; bm.we_i = 1'b1; bm.addr_i = 32'h10; bm.sel_i = 4'hF; bm.data_i = 32'h55555555;
        i0.ce_i = 1'b0; i0.we_i = 1'b0; i0.addr_i = 32'h0;  i0.sel_i = 4'hF; i0.data_i = 32'h0;
        i3.ce_i = 1'b0; i3.we_i = 1'b0; i3.addr_i = 32'h0;  i3.sel_i = 4'hF; i3.data_i = 32'h0;

        // Reset held with a request pending: nothing may come out, nothing captured.
        rst = 1'b0;
        repeat (4) @(negedge clk);
        bm.ce_i = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_no_ack", {31'd0, bm.ack_o}, 32'd0);
        chk("reset_data_o", bm.data_o, 32'd0);

        // Write then read-back; ack follows edge N+2, i.e. observed at cycle N+2.
        access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, n);
        chk("wr_latency", 32'(last_ack_cyc - n), 32'd2);
        access(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, n);
        chk("rd_latency", 32'(last_ack_cyc - n), 32'd2);
        chk("rd_deadbeef", last_ack_data, 32'hDEADBEEF);

        // Byte lanes, and a write with no lanes enabled.
        access(1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, n);
        access(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b0, n);
        access(1'b0, 32'h23, 4'h0, 32'h0, 1'b0, n);
        chk("byte_lanes", last_ack_data, 32'h11BB33DD);
        access(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 1'b0, n);
        access(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, n);
        chk("sel0_no_write", last_ack_data, 32'h11BB33DD);

        // ce_i held through the ack: a second access starts in the following IDLE cycle.
        access(1'b0, 32'h10, 4'hF, 32'h0, 1'b1, n);
        chk("hold_first_ack", 32'(prev_ack_cyc - n), 32'd2);
        chk("hold_ack_spacing", 32'(last_ack_cyc - prev_ack_cyc), 32'd4);
        chk("hold_second_data", last_ack_data, 32'hDEADBEEF);

        // High address bits: bus error when enabled, otherwise alias onto word 0.
        access(1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, n);
        access(1'b0, 32'h00001000, 4'hF, 32'h0, 1'b0, n);
`ifdef DATA_RAM_BUSERR_EN
        chk("hiaddr_err_cycle", 32'(last_err_cyc - n), 32'd2);
`else
        chk("hiaddr_alias_data", last_ack_data, 32'hCAFEF00D);
`endif
        access(1'b1, 32'h00001000, 4'hF, 32'h0BADBAD0, 1'b0, n);
        access(1'b0, 32'h0, 4'hF, 32'h0, 1'b0, n);
`ifdef DATA_RAM_BUSERR_EN
        chk("hiaddr_no_write", last_ack_data, 32'hCAFEF00D);
`else
        chk("hiaddr_alias_write", last_ack_data, 32'h0BADBAD0);
`endif

        // Zero wait states: ack in the cycle right after the capture edge.
        @(negedge clk);
        i0.ce_i = 1'b1; i0.we_i = 1'b1; i0.addr_i = 32'h40; i0.data_i = 32'h12345678;
        @(negedge clk);
        chk("d0_wr_ack", {31'd0, i0.ack_o}, 32'd1);
        i0.ce_i = 1'b0;
        @(negedge clk);
        chk("d0_ack_single", {31'd0, i0.ack_o}, 32'd0);
        i0.ce_i = 1'b1; i0.we_i = 1'b0; i0.data_i = 32'h0;
        @(negedge clk);
        chk("d0_rd_ack", {31'd0, i0.ack_o}, 32'd1);
        chk("d0_rd_data", i0.data_o, 32'h12345678);
        i0.ce_i = 1'b0;
        @(negedge clk);
        chk("d0_ack_drop", {31'd0, i0.ack_o}, 32'd0);
        chk("d0_data_clear", i0.data_o, 32'd0);

        // Three wait states, then a write aborted by reset mid-WAIT.
        d3_access(1'b1, 32'h80, 32'h0A0B0C0D, rd);
        @(negedge clk);
        i3.ce_i = 1'b1; i3.we_i = 1'b1; i3.addr_i = 32'h80; i3.data_i = 32'hFFFFFFFF;
        @(negedge clk);
        i3.ce_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("d3_rst_ack", {31'd0, i3.ack_o}, 32'd0);
        chk("d3_rst_data", i3.data_o, 32'd0);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("d3_no_stale_ack", {31'd0, i3.ack_o}, 32'd0);
        end
        d3_access(1'b0, 32'h80, 32'h0, rd);
        chk("d3_abort_keeps_old", rd, 32'h0A0B0C0D);

        repeat (3) @(negedge clk);
        chk("model_queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
